if_fetch_ctrl: RTL and testbench

- Fetch-stage sequencer for the Lagarto0 front end.
- Owns the fetch PC and issues one 64-bit line request at a time to the instruction cache.
- Writes each returned fetch block (FETCH_WIDTH=2 instructions) into the instruction queue, gated by queue credits.
- Handles redirects from later stages: squashes the in-flight request and flushes the queue.

---
 rtl/if_fetch_ctrl.sv | 145 ++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl
// Fetch-stage sequencer. It owns the fetch PC, keeps at most one 64-bit line
// request in flight to the instruction cache, and writes each returned fetch
// block (two 32-bit instructions) into the instruction queue. Queue credits
// gate new requests. Redirects squash the in-flight request and flush the
// queue.
//
// Ports
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   redirect_valid_i/pc  redirect request and target (bits [1:0] ignored)
//   stall_i              holds off new icache requests
//   icache_req_*         line request handshake and line-aligned address
//   icache_resp_*        one-cycle response pulse with the 64-bit block
//   iq_free_i            free instruction-queue slots
//   iq_wr_*              registered block write (data, PC, slot mask)
//   iq_flush_o           one-cycle queue flush after a redirect
//   fetch_pc_o           current fetch PC
`timescale 1ns/1ps
module if_fetch_ctrl #(
  parameter int                   ADDR_SIZE     = 64,
  parameter int                   VADD_SIZE     = 40,
  parameter int                   IBLOCK_BYTE   = 8,
  parameter int                   IQUEUE_DEPTH  = 4,
  parameter logic [ADDR_SIZE-1:0] RESET_ADDRESS = 64'h0
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic                            redirect_valid_i,
  input  logic [ADDR_SIZE-1:0]            redirect_pc_i,
  input  logic                            stall_i,
  output logic                            icache_req_valid_o,
  input  logic                            icache_req_ready_i,
  output logic [VADD_SIZE-1:0]            icache_req_vaddr_o,
  input  logic                            icache_resp_valid_i,
  input  logic [63:0]                     icache_resp_data_i,
  input  logic [$clog2(IQUEUE_DEPTH):0]   iq_free_i,
  output logic                            iq_wr_valid_o,
  output logic [63:0]                     iq_wr_data_o,
  output logic [ADDR_SIZE-1:0]            iq_wr_pc_o,
  output logic [1:0]                      iq_wr_mask_o,
  output logic                            iq_flush_o,
  output logic [ADDR_SIZE-1:0]            fetch_pc_o
);

  localparam int FREE_W = $clog2(IQUEUE_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_KILL = 2'd3
  } state_t;

  state_t                r_state;
  logic [ADDR_SIZE-1:0]  r_pc;
  logic                  r_wr_valid;
  logic [63:0]           r_wr_data;
  logic [ADDR_SIZE-1:0]  r_wr_pc;
  logic [1:0]            r_wr_mask;
  logic                  r_flush;

  logic [1:0]            w_mask;
  logic [FREE_W-1:0]     w_need;
  logic                  w_redirect;
  logic                  w_wr_valid;
  logic                  w_req_valid;
  logic                  w_handshake;
  logic [ADDR_SIZE-1:0]  w_redir_pc;
  logic [ADDR_SIZE-1:0]  w_pc_next;

  // A PC in the upper half of the block only carries one live instruction.
  assign w_mask     = r_pc[2] ? 2'b10 : 2'b11;
  assign w_need     = r_pc[2] ? FREE_W'(1) : FREE_W'(2);
  assign w_redirect = redirect_valid_i && (r_state != S_IDLE);
  assign w_redir_pc = redirect_pc_i & ~ADDR_SIZE'(3);
  assign w_pc_next  = {r_pc[ADDR_SIZE-1:3], 3'b000} + ADDR_SIZE'(IBLOCK_BYTE);

  // A write presented in the same cycle as a redirect is dropped: the queue
  // is about to be flushed anyway.
  assign w_wr_valid = r_wr_valid && !w_redirect;

  // While a write is being presented, iq_free_i does not yet account for it,
  // so no request may be launched on stale credit.
  assign w_req_valid = (r_state == S_REQ) && !stall_i && !w_wr_valid &&
                       (iq_free_i >= w_need);
  assign w_handshake = w_req_valid && icache_req_ready_i;

  assign icache_req_valid_o = w_req_valid;
  assign icache_req_vaddr_o = {r_pc[VADD_SIZE-1:3], 3'b000};
  assign iq_wr_valid_o      = w_wr_valid;
  assign iq_wr_data_o       = r_wr_data;
  assign iq_wr_pc_o         = r_wr_pc;
  assign iq_wr_mask_o       = r_wr_mask;
  assign iq_flush_o         = r_flush;
  assign fetch_pc_o         = r_pc;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_ADDRESS;
      r_wr_valid <= 1'b0;
      r_wr_data  <= '0;
      r_wr_pc    <= '0;
      r_wr_mask  <= '0;
      r_flush    <= 1'b0;
    end else begin
      r_wr_valid <= 1'b0;
      r_flush    <= w_redirect;
      if (w_redirect) begin
        r_pc <= w_redir_pc;
      end
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
        end
        S_REQ: begin
          // A request accepted alongside a redirect still returns data,
          // which must be swallowed in KILL.
          if (w_handshake) begin
            r_state <= w_redirect ? S_KILL : S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_redirect) begin
            r_state <= icache_resp_valid_i ? S_REQ : S_KILL;
          end else if (icache_resp_valid_i) begin
            r_wr_valid <= 1'b1;
            r_wr_data  <= icache_resp_data_i;
            r_wr_pc    <= r_pc;
            r_wr_mask  <= w_mask;
            r_pc       <= w_pc_next;
            r_state    <= S_REQ;
          end
        end
        S_KILL: begin
          if (icache_resp_valid_i) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl. The stimulus side drives inputs on the
// falling edge and runs a transaction-level model that queues the expected
// requests, queue writes, flushes and per-cycle status; a separate monitor
// pops and compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_if_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        stall_i = 1'b0;
  logic        icache_req_valid_o;
  logic        icache_req_ready_i = 1'b0;
  logic [39:0] icache_req_vaddr_o;
  logic        icache_resp_valid_i = 1'b0;
  logic [63:0] icache_resp_data_i = '0;
  logic [2:0]  iq_free_i = 3'd4;
  logic        iq_wr_valid_o;
  logic [63:0] iq_wr_data_o;
  logic [63:0] iq_wr_pc_o;
  logic [1:0]  iq_wr_mask_o;
  logic        iq_flush_o;
  logic [63:0] fetch_pc_o;

  if_fetch_ctrl dut (
    .clk_i               (clk_i),
    .rstn_i              (rstn_i),
    .redirect_valid_i    (redirect_valid_i),
    .redirect_pc_i       (redirect_pc_i),
    .stall_i             (stall_i),
    .icache_req_valid_o  (icache_req_valid_o),
    .icache_req_ready_i  (icache_req_ready_i),
    .icache_req_vaddr_o  (icache_req_vaddr_o),
    .icache_resp_valid_i (icache_resp_valid_i),
    .icache_resp_data_i  (icache_resp_data_i),
    .iq_free_i           (iq_free_i),
    .iq_wr_valid_o       (iq_wr_valid_o),
    .iq_wr_data_o        (iq_wr_data_o),
    .iq_wr_pc_o          (iq_wr_pc_o),
    .iq_wr_mask_o        (iq_wr_mask_o),
    .iq_flush_o          (iq_flush_o),
    .fetch_pc_o          (fetch_pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { int cyc; bit rv; logic [63:0] pc; } cyc_exp_t;
  typedef struct packed { int cyc; logic [39:0] vaddr; } req_exp_t;
  typedef struct packed { int cyc; logic [63:0] data; logic [63:0] pc; logic [1:0] mask; } wr_exp_t;

  cyc_exp_t exp_cyc[$];
  req_exp_t exp_req[$];
  wr_exp_t  exp_wr[$];
  int       exp_flush[$];
  int       resp_sched[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit in_reset = 1'b1;
  int dly_min = 2;
  int dly_max = 2;

  // Transaction-level model of the fetch unit.
  logic [63:0] m_pc;
  bit          m_started, m_busy, m_squashed, m_wr_pend;
  wr_exp_t     m_pend_item;

  task automatic model_reset();
    m_pc = 64'h0; m_started = 0; m_busy = 0; m_squashed = 0; m_wr_pend = 0;
    exp_cyc.delete(); exp_req.delete(); exp_wr.delete(); exp_flush.delete();
  endtask

  task automatic do_cycle(input bit redir, input logic [63:0] rpc, input bit stall,
                          input bit rdy, input logic [2:0] free);
    bit          resp, redir_eff, wr_vis, rv, hs;
    logic [63:0] rdata;
    int          need;
    @(negedge clk_i);
    cyc++;
    resp = 0;
    for (int i = 0; i < resp_sched.size(); i++) begin
      if (resp_sched[i] == cyc) begin
        resp = 1;
        resp_sched.delete(i);
        break;
      end
    end
    rdata = {$urandom, $urandom};
    redirect_valid_i    = redir;
    redirect_pc_i       = rpc;
    stall_i             = stall;
    icache_req_ready_i  = rdy;
    iq_free_i           = free;
    icache_resp_valid_i = resp;
    icache_resp_data_i  = rdata;
    #1;
    redir_eff = redir && m_started;
    wr_vis    = m_wr_pend && !redir_eff;
    if (wr_vis) begin
      m_pend_item.cyc = cyc;
      exp_wr.push_back(m_pend_item);
    end
    need = m_pc[2] ? 1 : 2;
    rv = m_started && !m_busy && !stall && !wr_vis && (int'(free) >= need);
    hs = rv && rdy;
    exp_cyc.push_back('{cyc: cyc, rv: rv, pc: m_pc});
    if (hs) begin
      exp_req.push_back('{cyc: cyc, vaddr: m_pc[39:0] & ~40'h7});
      resp_sched.push_back(cyc + int'($urandom_range(dly_max, dly_min)));
    end
    if (redir_eff) exp_flush.push_back(cyc + 1);
    m_wr_pend = 0;
    if (!m_started) begin
      m_started = 1;
    end else if (redir_eff) begin
      m_pc = rpc & ~64'h3;
      if (m_busy) begin
        if (resp) begin m_busy = 0; m_squashed = 0; end
        else m_squashed = 1;
      end else if (hs) begin
        m_busy = 1; m_squashed = 1;
      end
    end else if (m_busy) begin
      if (resp) begin
        if (!m_squashed) begin
          m_pend_item = '{cyc: 0, data: rdata, pc: m_pc,
                          mask: (m_pc[2] ? 2'b10 : 2'b11)};
          m_wr_pend = 1;
          m_pc = (m_pc & ~64'h7) + 64'd8;
        end
        m_busy = 0; m_squashed = 0;
      end
    end else if (hs) begin
      m_busy = 1; m_squashed = 0;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  task automatic miss(input string name, input int stamp);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d expected event at cyc %0d not seen", name, cyc, stamp);
  endtask

  task automatic apply_reset();
    @(posedge clk_i);
    #1;
    rstn_i = 1'b0;
    in_reset = 1'b1;
    model_reset();
    repeat (3) begin
      @(negedge clk_i);
      #3;
      chk("rst_req_valid", {63'b0, icache_req_valid_o}, 64'h0);
      chk("rst_wr_valid", {63'b0, iq_wr_valid_o}, 64'h0);
      chk("rst_flush", {63'b0, iq_flush_o}, 64'h0);
      chk("rst_wr_data", iq_wr_data_o, 64'h0);
      chk("rst_wr_pc", iq_wr_pc_o, 64'h0);
      chk("rst_wr_mask", {62'b0, iq_wr_mask_o}, 64'h0);
      chk("rst_fetch_pc", fetch_pc_o, 64'h0);
      $display("reset cycle: req_valid=%0b wr_valid=%0b pc=%h", icache_req_valid_o,
               iq_wr_valid_o, fetch_pc_o);
    end
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    in_reset = 1'b0;
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  initial begin
    cyc_exp_t c;
    req_exp_t r;
    wr_exp_t  w;
    forever begin
      @(negedge clk_i);
      #3;
      if (!in_reset && exp_cyc.size() > 0 && exp_cyc[0].cyc == cyc) begin
        c = exp_cyc.pop_front();
        chk("req_valid", {63'b0, icache_req_valid_o}, {63'b0, c.rv});
        chk("fetch_pc", fetch_pc_o, c.pc);
        while (exp_req.size() > 0 && exp_req[0].cyc < cyc) miss("req", exp_req.pop_front().cyc);
        while (exp_wr.size() > 0 && exp_wr[0].cyc < cyc) miss("iq_wr", exp_wr.pop_front().cyc);
        while (exp_flush.size() > 0 && exp_flush[0] < cyc) miss("flush", exp_flush.pop_front());
        if (icache_req_valid_o && icache_req_ready_i) begin
          if (exp_req.size() > 0 && exp_req[0].cyc == cyc) begin
            r = exp_req.pop_front();
            chk("req_vaddr", {24'b0, icache_req_vaddr_o}, {24'b0, r.vaddr});
            $display("cyc %0d req vaddr=%h", cyc, icache_req_vaddr_o);
          end else begin
            chk("req_unexpected", {24'b0, icache_req_vaddr_o}, 64'hDEAD);
          end
        end
        if (iq_wr_valid_o) begin
          if (exp_wr.size() > 0 && exp_wr[0].cyc == cyc) begin
            w = exp_wr.pop_front();
            chk("iq_wr_data", iq_wr_data_o, w.data);
            chk("iq_wr_pc", iq_wr_pc_o, w.pc);
            chk("iq_wr_mask", {62'b0, iq_wr_mask_o}, {62'b0, w.mask});
            $display("cyc %0d iq write pc=%h mask=%b data=%h", cyc, iq_wr_pc_o,
                     iq_wr_mask_o, iq_wr_data_o);
          end else begin
            chk("iq_wr_unexpected", iq_wr_pc_o, 64'hDEAD);
          end
        end
        if (iq_flush_o) begin
          if (exp_flush.size() > 0 && exp_flush[0] == cyc) begin
            void'(exp_flush.pop_front());
            checks++;
            $display("cyc %0d flush", cyc);
          end else begin
            chk("flush_unexpected", {63'b0, iq_flush_o}, 64'h0);
          end
        end
      end
    end
  end

  initial begin
    bit          redir;
    logic [63:0] rpc;
    apply_reset();

    // Straight-line fetch from the reset address.
    dly_min = 2; dly_max = 2;
    repeat (14) do_cycle(0, 64'h0, 0, 1, 3'd4);

    // Redirect to an upper-half PC.
    do_cycle(1, 64'h1004, 0, 0, 3'd4);
    repeat (12) do_cycle(0, 64'h0, 0, 1, 3'd4);

    // Redirect while a live request is waiting for data.
    dly_min = 3; dly_max = 3;
    for (int k = 0; k < 20 && !(m_busy && !m_squashed); k++) do_cycle(0, 64'h0, 0, 1, 3'd4);
    do_cycle(1, 64'h2000, 0, 1, 3'd4);
    repeat (12) do_cycle(0, 64'h0, 0, 1, 3'd4);

    // Credit gating at an aligned and an upper-half PC.
    dly_min = 2; dly_max = 2;
    do_cycle(1, 64'h0, 0, 0, 3'd4);
    repeat (6) do_cycle(0, 64'h0, 0, 1, 3'd1);
    repeat (6) do_cycle(0, 64'h0, 0, 1, 3'd2);
    do_cycle(1, 64'h4, 0, 0, 3'd1);
    repeat (6) do_cycle(0, 64'h0, 0, 1, 3'd1);

    // Stall with the cache not ready, then release.
    repeat (5) do_cycle(0, 64'h0, 1, 0, 3'd4);
    repeat (6) do_cycle(0, 64'h0, 0, 1, 3'd4);

    // PC wrap at the top of the address space.
    do_cycle(1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 3'd4);
    repeat (10) do_cycle(0, 64'h0, 0, 1, 3'd4);

    // Reset while a request is outstanding; its late response must be ignored.
    dly_min = 3; dly_max = 3;
    for (int k = 0; k < 20 && !m_busy; k++) do_cycle(0, 64'h0, 0, 1, 3'd4);
    apply_reset();
    repeat (4) do_cycle(0, 64'h0, 0, 0, 3'd4);
    repeat (8) do_cycle(0, 64'h0, 0, 1, 3'd4);

    // Randomized traffic.
    dly_min = 1; dly_max = 4;
    for (int n = 0; n < 3000; n++) begin
      redir = ($urandom_range(99) < 6);
      case ($urandom_range(3))
        0:       rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
        1:       rpc = 64'($urandom_range(255));
        default: rpc = {$urandom, $urandom};
      endcase
      do_cycle(redir, rpc, ($urandom_range(99) < 20), ($urandom_range(99) < 60),
               3'($urandom_range(4)));
    end

    // Drain: no new requests, let outstanding responses and writes complete.
    repeat (10) do_cycle(0, 64'h0, 1, 0, 3'd4);
    #5;
    while (exp_req.size() > 0) miss("req_left", exp_req.pop_front().cyc);
    while (exp_wr.size() > 0) miss("iq_wr_left", exp_wr.pop_front().cyc);
    while (exp_flush.size() > 0) miss("flush_left", exp_flush.pop_front());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
